// File: rtl/pkt_dispatch_pkg.sv
// Shared constants, beat layout and scheduler state encoding for pkt_dispatch_sched.
package pkt_dispatch_pkg;

  localparam int unsigned PKT_W       = 601;
  localparam int unsigned META_W      = 88;
  localparam int unsigned DATA_W      = 512;
  localparam int unsigned TLAST_BIT   = 512;
  localparam int unsigned SESSION_LSB = 0;
  localparam int unsigned SESSION_W   = 16;

  // One receiver beat: {metadata, tlast, data}, tlast lands on bit TLAST_BIT.
  typedef struct packed {
    logic [META_W-1:0] meta;
    logic              tlast;
    logic [DATA_W-1:0] data;
  } pkt_beat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pkt_dispatch_sched_credit.sv
// Per-lane outstanding-message counter; lane may take a new message while below the limit.
module lane_credit_ctr #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic has_credit,
  output logic underflow
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] cnt_q;

  assign has_credit = (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign underflow  = dec && (cnt_q == '0);

  // Count accepted messages up, retired messages down; a retire at zero is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && !dec) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pkt_dispatch_sched.sv
// Whole-message scheduler from the receiver stream to NUM_LANES top-k worker lanes.
// Round-robin by default; define DISPATCH_AFFINITY_EN to steer by session id instead.
module pkt_dispatch_sched
  import pkt_dispatch_pkg::*;
#(
  parameter int unsigned NUM_LANES       = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned PKT_W           = pkt_dispatch_pkg::PKT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PKT_W-1:0]             s_axis_pkt_TDATA,
  input  logic                         s_axis_pkt_TVALID,
  output logic                         s_axis_pkt_TREADY,
  output logic [PKT_W-1:0]             m_axis_pkt_TDATA,
  output logic [NUM_LANES-1:0]         m_axis_pkt_TVALID,
  input  logic [NUM_LANES-1:0]         m_axis_pkt_TREADY,
  input  logic [NUM_LANES-1:0]         lane_done,
  output logic [$clog2(NUM_LANES)-1:0] grant_lane,
  output logic                         busy,
  output logic                         credit_err
);

  localparam int unsigned LANE_W = $clog2(NUM_LANES);

  sched_state_e         state_q, state_d;
  logic [LANE_W-1:0]    rr_q, rr_d;
  logic [LANE_W-1:0]    grant_q, grant_d;
  logic                 busy_q;
  logic                 credit_err_q;
  logic [NUM_LANES-1:0] has_credit;
  logic [NUM_LANES-1:0] underflow;
  logic [NUM_LANES-1:0] inc;
  logic                 found;
  logic [LANE_W-1:0]    pick;
  pkt_beat_t            beat;

  assign beat             = pkt_beat_t'(s_axis_pkt_TDATA);
  assign m_axis_pkt_TDATA = beat;

  // One credit counter per lane; retirements are honoured in every state.
  for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
    lane_credit_ctr #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[i]),
      .dec       (lane_done[i]),
      .has_credit(has_credit[i]),
      .underflow (underflow[i])
    );
  end

`ifdef DISPATCH_AFFINITY_EN
  // Session affinity: the head beat's session id picks the lane, no fallback.
  always_comb begin
    pick  = LANE_W'(beat.meta[SESSION_LSB +: SESSION_W] % SESSION_W'(NUM_LANES));
    found = has_credit[pick];
  end
`else
  // Round-robin: first lane with credit after rr; reverse scan lets the nearest win.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = NUM_LANES; k >= 1; k--) begin
      idx = (32'(rr_q) + k) % NUM_LANES;
      if (has_credit[LANE_W'(idx)]) begin
        found = 1'b1;
        pick  = LANE_W'(idx);
      end
    end
  end
`endif

  // Next-state and stream steering.
  always_comb begin
    state_d           = state_q;
    rr_d              = rr_q;
    grant_d           = grant_q;
    inc               = '0;
    s_axis_pkt_TREADY = 1'b0;
    m_axis_pkt_TVALID = '0;
    unique case (state_q)
      IDLE: begin
        if (s_axis_pkt_TVALID) state_d = ARB;
      end
      ARB: begin
        if (found) begin
          grant_d = pick;
          rr_d    = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        m_axis_pkt_TVALID[grant_q] = s_axis_pkt_TVALID;
        s_axis_pkt_TREADY          = m_axis_pkt_TREADY[grant_q];
        if (s_axis_pkt_TVALID && m_axis_pkt_TREADY[grant_q] && beat.tlast) begin
          inc[grant_q] = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, grant and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= LANE_W'(NUM_LANES - 1);
      grant_q      <= '0;
      busy_q       <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      busy_q  <= (state_d == XFER);
      if (|underflow) credit_err_q <= 1'b1;
    end
  end

  assign grant_lane = grant_q;
  assign busy       = busy_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_pkt_dispatch_sched.sv
// Self-checking bench for pkt_dispatch_sched: directed table, corner sequences, random traffic.
module tb_pkt_dispatch_sched;
  import pkt_dispatch_pkg::*;

  localparam int NL   = 4;
  localparam int MAXO = 2;
  localparam int PW   = 601;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] m_data;
  logic [NL-1:0] m_valid;
  logic [NL-1:0] m_ready;
  logic [NL-1:0] lane_done;
  logic [1:0]    grant_lane;
  logic          busy;
  logic          credit_err;

  always #5 clk = ~clk;

  pkt_dispatch_sched #(
    .NUM_LANES(NL), .MAX_OUTSTANDING(MAXO), .PKT_W(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_pkt_TDATA(s_data), .s_axis_pkt_TVALID(s_valid), .s_axis_pkt_TREADY(s_ready),
    .m_axis_pkt_TDATA(m_data), .m_axis_pkt_TVALID(m_valid), .m_axis_pkt_TREADY(m_ready),
    .lane_done(lane_done), .grant_lane(grant_lane), .busy(busy), .credit_err(credit_err)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference: per-lane outstanding messages, last winner, sticky error.
  int m_cnt[NL];
  int m_rr;
  bit m_err;
  int exp_beats[NL];
  int seen_beats[NL];

  // Independent count of beats delivered to each lane.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NL; i++)
        if (m_valid[i] && m_ready[i]) seen_beats[i] <= seen_beats[i] + 1;
    end
  end

  typedef struct {
    int          len;
    logic [15:0] sess;
    int          exp_lane;
    int          stall_beat;
    int          stall_len;
  } vec_t;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_data(string name, logic [PW-1:0] got, logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [PW-1:0] make_beat(logic [15:0] sess, logic last);
    logic [PW-1:0] b;
    b = '0;
    for (int i = 0; i < 19; i++) b = (b << 32) | PW'($urandom);
    b[512]        = last;
    b[513 +: 16]  = sess;
    return b;
  endfunction

  function automatic logic [NL-1:0] onehot(int l);
    logic [NL-1:0] v;
    v    = '0;
    v[l] = 1'b1;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    m_rr  = NL - 1;
    m_err = 1'b0;
  endfunction

  function automatic void model_done(int l);
    if (m_cnt[l] == 0) m_err = 1'b1;
    else m_cnt[l] = m_cnt[l] - 1;
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= NL; k++)
      if (m_cnt[(m_rr + k) % NL] < MAXO) return (m_rr + k) % NL;
    return -1;
  endfunction

  function automatic int model_pick(logic [15:0] sess);
`ifdef DISPATCH_AFFINITY_EN
    int c;
    c = int'(sess) % NL;
    return (m_cnt[c] < MAXO) ? c : -1;
`else
    if (sess == 16'hffff) return rr_pick();
    return rr_pick();
`endif
  endfunction

  function automatic int any_busy_lane();
    int off;
    off = int'($urandom_range(0, NL - 1));
    for (int k = 0; k < NL; k++)
      if (m_cnt[(off + k) % NL] > 0) return (off + k) % NL;
    return -1;
  endfunction

  task automatic check_reset_outputs(string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant"}, 32'(grant_lane), 32'd0);
    chk({tag, "_credit_err"}, 32'(credit_err), 32'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    lane_done = '0;
    m_ready   = '1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic pulse_done(int l);
    lane_done    = '0;
    lane_done[l] = 1'b1;
    tick();
    lane_done = '0;
    model_done(l);
  endtask

  // Offer one message, expect it on exp lane after exactly 2 cycles, check every beat.
  task automatic send_msg(int len, logic [15:0] sess, int exp, bit rnd, int stall_beat,
                          int stall_len, bit done_last, string tag);
    logic [PW-1:0] b;
    int lat;
    int w;
    int dl;
    b       = make_beat(sess, len == 1);
    s_data  = b;
    s_valid = 1'b1;
    m_ready = '1;
    settle();
    lat = 0;
    while (m_valid == '0 && lat < 50) begin
      tick();
      lat++;
    end
    if (lat >= 50) begin
      failures++;
      checks++;
      $display("FAIL %s_grant_timeout: got no grant expected lane %0d", tag, exp);
      s_valid = 1'b0;
      return;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    for (int k = 0; k < len; k++) begin
      if (k > 0) begin
        b = make_beat(sess, k == len - 1);
        if (rnd && $urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          settle();
          repeat ($urandom_range(1, 3)) begin
            tick();
            chk({tag, "_gap_busy"}, 32'(busy), 32'd1);
            chk({tag, "_gap_valid"}, 32'(m_valid), 32'd0);
          end
        end
        s_data  = b;
        s_valid = 1'b1;
      end
      if (k == stall_beat) begin
        m_ready[exp] = 1'b0;
        settle();
        repeat (stall_len) begin
          chk({tag, "_stall_s_ready"}, 32'(s_ready), 32'd0);
          chk({tag, "_stall_valid"}, 32'(m_valid), 32'(onehot(exp)));
          tick();
        end
        m_ready[exp] = 1'b1;
      end
      if (rnd) m_ready = NL'($urandom);
      settle();
      w = 0;
      while (!s_ready && w < 100) begin
        tick();
        if (rnd) m_ready = NL'($urandom);
        settle();
        w++;
      end
      if (w >= 100) begin
        failures++;
        checks++;
        $display("FAIL %s_beat_timeout: got s_ready=0 expected handshake on beat %0d", tag, k);
        s_valid = 1'b0;
        return;
      end
      chk({tag, "_valid"}, 32'(m_valid), 32'(onehot(exp)));
      chk({tag, "_grant"}, 32'(grant_lane), 32'(exp));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk_data({tag, "_data"}, m_data, b);
      dl = -1;
      if (done_last && k == len - 1) dl = exp;
      else if (rnd && $urandom_range(0, 3) == 0) dl = any_busy_lane();
      if (dl >= 0) lane_done[dl] = 1'b1;
      tick();
      lane_done = '0;
      if (dl >= 0) model_done(dl);
    end
    s_valid      = 1'b0;
    m_cnt[exp]   = m_cnt[exp] + 1;
    m_rr         = exp;
    exp_beats[exp] = exp_beats[exp] + len;
    settle();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  // Send with the lane the round-robin model predicts; session chosen to map to that lane.
  task automatic send_auto(int len, bit done_last, string tag);
    int l;
    logic [15:0] sess;
    l    = rr_pick();
    sess = 16'(NL * int'($urandom_range(0, 1000)) + l);
    send_msg(len, sess, model_pick(sess), 1'b0, -1, 0, done_last, tag);
  endtask

  // Message with no lane available: held in arbitration until rel lane retires one.
  task automatic stall_release(logic [15:0] sess, int n, int rel, string tag);
    s_data  = make_beat(sess, 1'b1);
    s_valid = 1'b1;
    m_ready = '1;
    settle();
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_hold_busy"}, 32'(busy), 32'd0);
    end
    lane_done      = '0;
    lane_done[rel] = 1'b1;
    tick();
    lane_done = '0;
    model_done(rel);
    chk({tag, "_done_cycle_valid"}, 32'(m_valid), 32'd0);
    tick();
    chk({tag, "_release_valid"}, 32'(m_valid), 32'(onehot(rel)));
    chk({tag, "_release_grant"}, 32'(grant_lane), 32'(rel));
    chk({tag, "_release_ready"}, 32'(s_ready), 32'd1);
    tick();
    s_valid        = 1'b0;
    m_cnt[rel]     = m_cnt[rel] + 1;
    m_rr           = rel;
    exp_beats[rel] = exp_beats[rel] + 1;
    settle();
    chk({tag, "_after_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   snap[NL];
    int   e;
    logic [15:0] sess;

    vt[0] = '{1, 16'd0, 0, -1, 0};
    vt[1] = '{1, 16'd1, 1, -1, 0};
    vt[2] = '{1, 16'd2, 2, -1, 0};
    vt[3] = '{1, 16'd3, 3, -1, 0};
    vt[4] = '{2, 16'd4, 0, -1, 0};
    vt[5] = '{3, 16'd5, 1,  1, 5};
    vt[6] = '{1, 16'd6, 2, -1, 0};
    vt[7] = '{4, 16'd7, 3, -1, 0};

    do_reset();
    check_reset_outputs("reset");

    // Table: four single beats to lanes 0..3, then a second round including a stalled 3-beat.
    for (int i = 0; i < 8; i++)
      send_msg(vt[i].len, vt[i].sess, vt[i].exp_lane, 1'b0, vt[i].stall_beat,
               vt[i].stall_len, 1'b0, $sformatf("vec%0d", i));
    chk("vec_credit_err", 32'(credit_err), 32'd0);
    stall_release(16'd2, 6, 2, "ninth");

    // Retire at zero raises the sticky error and leaves the lane count at zero.
    do_reset();
    pulse_done(3);
    chk("underflow_err", 32'(credit_err), 32'(m_err));
    repeat (5) tick();
    chk("underflow_sticky", 32'(credit_err), 32'd1);
    for (int i = 0; i < 8; i++) send_auto(1, 1'b0, "uf_fill");
    stall_release(16'd3, 4, 3, "uf_full");
    chk("underflow_still", 32'(credit_err), 32'd1);
    do_reset();
    check_reset_outputs("uf_reset");

    // Retire and accept on the same lane in the same cycle cancel out.
    for (int i = 0; i < 4; i++) send_auto(1, 1'b0, "sim_pre");
    send_auto(1, 1'b1, "sim_both");
    chk("sim_credit_err", 32'(credit_err), 32'd0);
    for (int i = 0; i < 4; i++) send_auto(1, 1'b0, "sim_post");
    stall_release(16'd0, 4, 0, "sim_full");

`ifdef DISPATCH_AFFINITY_EN
    // Sessions 5, 9, 5 all belong to lane 1; the third waits for a lane 1 credit.
    do_reset();
    send_msg(2, 16'd5, 1, 1'b0, -1, 0, 1'b0, "aff5");
    send_msg(1, 16'd9, 1, 1'b0, -1, 0, 1'b0, "aff9");
    stall_release(16'd5, 3, 1, "aff5b");
`endif

    // Reset in the middle of a transfer.
    do_reset();
    s_data  = make_beat(16'd0, 1'b0);
    s_valid = 1'b1;
    settle();
    tick();
    tick();
    chk("midrst_valid", 32'(m_valid), 32'(onehot(0)));
    tick();
    s_data = make_beat(16'd0, 1'b0);
    rst    = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst     = 1'b0;
    s_valid = 1'b0;
    model_reset();
    tick();

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < NL; i++) begin
      exp_beats[i] = 0;
      snap[i]      = seen_beats[i];
    end
    for (int n = 0; n < 60; n++) begin
      sess = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        e = any_busy_lane();
        if (e >= 0) pulse_done(e);
      end
      e = model_pick(sess);
      if (e < 0) begin
        pulse_done(int'(sess) % NL);
        e = model_pick(sess);
      end
      send_msg(int'($urandom_range(1, 4)), sess, e, 1'b1, -1, 0, 1'b0, "rnd");
    end
    tick();
    for (int i = 0; i < NL; i++)
      chk($sformatf("rnd_beats_lane%0d", i), 32'(seen_beats[i] - snap[i]), 32'(exp_beats[i]));
    chk("rnd_credit_err", 32'(credit_err), 32'(m_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_dispatch_sched.md
Name: pkt_dispatch_sched

Overview:
- Round-robin scheduler sharing the packet-receiver output stream (88b metadata + tlast + 512b data) between NUM_LANES top-k worker lanes.
- Grants a whole message (head beat through tlast) to one lane at a time.
- Limits the messages in flight per lane with credit counters; workers return credits with a done pulse.
- Sits between the receiver's packet FIFO output and the top-k worker array.

Parameters:
- NUM_LANES, 4, number of worker lanes (2..8).
- MAX_OUTSTANDING, 2, messages accepted by a lane but not yet retired by lane_done (1..15).
- PKT_W, 601, packet bus width: {metadata[87:0], tlast, data[511:0]}; tlast is bit 512.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_pkt_TDATA  in  PKT_W  packet beat from receiver
- s_axis_pkt_TVALID  in  1  beat valid
- s_axis_pkt_TREADY  out  1  beat accepted
- m_axis_pkt_TDATA  out  PKT_W  beat broadcast to all lanes (combinational copy of input)
- m_axis_pkt_TVALID  out  NUM_LANES  one-hot valid to the granted lane
- m_axis_pkt_TREADY  in  NUM_LANES  per-lane ready
- lane_done  in  NUM_LANES  1-cycle pulse per lane: one message retired
- grant_lane  out  clog2(NUM_LANES)  currently/last granted lane
- busy  out  1  a message is mid-transfer
- credit_err  out  1  sticky: lane_done seen while that lane's counter was 0

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, all counters 0, rr pointer=NUM_LANES-1 (lane 0 wins first).
  - grant_lane=0, busy=0, credit_err=0, TREADY=0, all m TVALID=0.
- States: IDLE, ARB, XFER.
- IDLE:
  - s TREADY=0.
  - If s TVALID=1 -> ARB next cycle. The head beat stays unconsumed.
- ARB (one cycle):
  - Eligible lane: outstanding[i] < MAX_OUTSTANDING.
  - Pick the first eligible lane searching from rr+1 with wrap modulo NUM_LANES.
  - If found: latch grant_lane, set rr=grant, go to XFER.
  - If none eligible: stay in ARB and re-evaluate every cycle (credits freed this cycle count next cycle).
  - Eligibility does not consider m TREADY; the credit guarantees buffer space.
- XFER:
  - busy=1.
  - m TVALID[g]=s TVALID; s TREADY=m TREADY[g]; other lanes TVALID=0.
  - On handshake with tlast=1: outstanding[g]+=1. Next state is IDLE; if s TVALID=0, the handshake was the last beat.
  - Minimum header-to-first-beat latency: 2 cycles (IDLE, ARB). Beats then stream at 1/cycle.
- Credit counters (width clog2(MAX_OUTSTANDING+1)):
  - Increment and lane_done on the same lane in the same cycle -> unchanged.
  - lane_done with counter 0 -> counter stays 0 and credit_err is set (sticky until rst).
  - Counter never exceeds MAX_OUTSTANDING by construction.
- lane_done is honoured in every state, including mid-XFER of the same lane.
- s TVALID drop mid-message (gap) -> remain in XFER; no timeout.
- Reset mid-XFER -> transfer abandoned and counters cleared. Upstream flushes via the same rst.
- Metadata is forwarded untouched; the scheduler reads only tlast.

Optional Feature:
- Macro DISPATCH_AFFINITY_EN.
- When defined: in ARB the candidate lane is metadata session id [15:0] modulo NUM_LANES, taken from the head beat, so all messages of a session go to one lane.
  - If that lane has no credit, wait in ARB; do not fall back.
  - The rr pointer is unused.
- When undefined: pure round-robin as above.
- Ports are identical in both builds.

Decomposition:
- Shared package pkt_dispatch_pkg:
  - constants PKT_W=601, META_W=88, DATA_W=512, TLAST_BIT=512, SESSION_LSB=0, SESSION_W=16.
  - state encoding IDLE=2'd0, ARB=2'd1, XFER=2'd2.
- One natural sub-module: lane_credit_ctr, one instance per lane.
  - Inputs: inc, dec.
  - Outputs: has_credit, underflow.

Test Plan:
- 4 single-beat messages (tlast=1), all TREADY=1, NUM_LANES=4 -> delivered to lanes 0,1,2,3 in order. Each head beat appears 2 cycles after TVALID rises.
- 3-beat message, lane 1 TREADY low for 5 cycles mid-message -> s TREADY tracks it, no beat lost or duplicated, lane 1 counter=1 after tlast.
- MAX_OUTSTANDING=2, no lane_done, 9 messages -> 8 dispatched (2 per lane), 9th waits in ARB. A lane_done[2] pulse -> 9th goes to lane 2 on the following cycle.
- lane_done[0] in the same cycle as the tlast handshake on lane 0 (counter=1) -> counter stays 1, credit_err=0.
- lane_done[3] with counter 0 -> credit_err=1, held until rst, counter stays 0.
- DISPATCH_AFFINITY_EN: session ids 5,9,5 with NUM_LANES=4 -> all three go to lane 1; rst asserted mid-message -> all outputs return to reset values the next cycle.
